// File: rtl/done_event_monitor_if.sv
// Handshake/status bundle between the done-event monitor and its host.
// The host (master) arms the monitor, feeds done levels, sets the threshold
// and acknowledges interrupts; the monitor (slave) reports edges, count,
// interrupt and overflow.
interface done_event_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             enable;
    logic             done_i;
    logic [CNT_W-1:0] threshold;
    logic             irq_ack;
    logic             done_rise_o;
    logic [CNT_W-1:0] event_cnt_o;
    logic             irq_o;
    logic             overflow_o;

    modport master (
        output enable,
        output done_i,
        output threshold,
        output irq_ack,
        input  done_rise_o,
        input  event_cnt_o,
        input  irq_o,
        input  overflow_o
    );

    modport slave (
        input  enable,
        input  done_i,
        input  threshold,
        input  irq_ack,
        output done_rise_o,
        output event_cnt_o,
        output irq_o,
        output overflow_o
    );
endinterface

// File: rtl/done_event_monitor.sv
// Done-event monitor: detects rising edges of an upstream done level, counts
// the edges accepted while armed, raises a held interrupt when the count
// reaches a programmable threshold, and flags a sticky overflow when the
// threshold is reached again before the interrupt was acknowledged.
// All outputs come straight from flops.
module done_event_monitor #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    done_event_monitor_if.slave   mon
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        IRQ   = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_done_q;
    logic             r_done_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             r_irq;
    logic             r_ovf;

    logic             w_rise;
    logic             w_accept;
    logic             w_hit;
    logic [CNT_W:0]   w_cnt_inc;

    // Edge detect against the unconditionally registered done level.
    assign w_rise    = mon.done_i & ~r_done_q;
    assign w_accept  = w_rise & mon.enable;
    // One bit wider so an all-ones count still compares correctly.
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_hit     = w_accept && (mon.threshold != '0)
                       && (w_cnt_inc >= {1'b0, mon.threshold});

    // Register done level every cycle and emit the one-cycle accepted-edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_q    <= 1'b0;
            r_done_rise <= 1'b0;
        end else begin
            r_done_q    <= mon.done_i;
            r_done_rise <= w_accept;
        end
    end

    // Control FSM: counting, interrupt raise/ack, overflow and disarm.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (!mon.enable) begin
            // Disarm discards any pending interrupt; overflow is sticky.
            r_state <= IDLE;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
        end else begin
            case (r_state)
                // IDLE holds a zero count, so an edge arriving on the arming
                // cycle is handled exactly as in COUNT.
                IDLE, COUNT: begin
                    if (w_hit) begin
                        r_cnt   <= '0;
                        r_irq   <= 1'b1;
                        r_state <= IRQ;
                    end else begin
                        if (w_accept) begin
                            r_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                        r_state <= COUNT;
                    end
                end
                IRQ: begin
                    if (w_hit) begin
                        // A simultaneous ack consumes the old interrupt and
                        // the hit raises a new one, so no overflow then.
                        r_cnt <= '0;
                        if (!mon.irq_ack) begin
                            r_ovf <= 1'b1;
                        end
                    end else begin
                        if (w_accept) begin
                            r_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                        if (mon.irq_ack) begin
                            r_irq   <= 1'b0;
                            r_state <= COUNT;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

    assign mon.done_rise_o = r_done_rise;
    assign mon.event_cnt_o = r_cnt;
    assign mon.irq_o       = r_irq;
    assign mon.overflow_o  = r_ovf;

endmodule

// File: tb/tb_done_event_monitor.sv
// Bench for done_event_monitor (CNT_W=4): directed scenarios followed by
// random traffic, all checked against a behavioural model of the rules.
module tb_done_event_monitor;

    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst;

    done_event_monitor_if #(.CNT_W(CW)) mon_if ();

    done_event_monitor #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: previous done level, pulse, count, pending irq, overflow.
    bit m_prev;
    bit m_rise;
    int m_cnt;
    bit m_irq;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".rise"}, 32'(mon_if.done_rise_o), 32'(m_rise));
        chk({tag, ".cnt"},  32'(mon_if.event_cnt_o), 32'(m_cnt));
        chk({tag, ".irq"},  32'(mon_if.irq_o),       32'(m_irq));
        chk({tag, ".ovf"},  32'(mon_if.overflow_o),  32'(m_ovf));
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare.
    task automatic cyc(input string tag, input bit r, input bit en, input bit d,
                       input int th, input bit ack);
        bit acc;
        bit hit;
        rst              = r;
        mon_if.enable    = en;
        mon_if.done_i    = d;
        mon_if.threshold = CW'(th);
        mon_if.irq_ack   = ack;
        if (r) begin
            m_prev = 0; m_rise = 0; m_cnt = 0; m_irq = 0; m_ovf = 0;
        end else begin
            acc    = d && !m_prev && en;
            m_rise = acc;
            m_prev = d;
            if (!en) begin
                m_cnt = 0;
                m_irq = 0;
            end else begin
                hit = acc && (th != 0) && (m_cnt + 1 >= th);
                if (hit) begin
                    if (m_irq && !ack) m_ovf = 1;
                    m_cnt = 0;
                    m_irq = 1;
                end else begin
                    if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
                    if (m_irq && ack) m_irq = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cmp_model(tag);
    endtask

    // Low cycle followed by a high cycle: one rising edge.
    task automatic pulse(input string tag, input int th, input bit ack);
        cyc({tag, ".lo"}, 0, 1, 0, th, 0);
        cyc({tag, ".hi"}, 0, 1, 1, th, ack);
    endtask

    initial begin
        int rises;
        bit irq_seen;
        rst = 1'b1;
        mon_if.enable = 1'b0; mon_if.done_i = 1'b0;
        mon_if.threshold = '0; mon_if.irq_ack = 1'b0;

        // Reset with done held high, then release while armed.
        cyc("rst0", 1, 1, 1, 3, 1);
        cyc("rst1", 1, 1, 1, 3, 1);
        chk("rst.cnt", 32'(mon_if.event_cnt_o), 0);
        chk("rst.irq", 32'(mon_if.irq_o), 0);
        chk("rst.ovf", 32'(mon_if.overflow_o), 0);
        chk("rst.rise", 32'(mon_if.done_rise_o), 0);
        cyc("rel", 0, 1, 1, 3, 0);
        chk("rel.rise", 32'(mon_if.done_rise_o), 1);

        // Threshold 3, three edges.
        cyc("r32.rst", 1, 1, 0, 3, 0);
        cyc("r32.arm", 0, 1, 0, 3, 0);
        pulse("r32.e1", 3, 0);
        chk("r32.e1rise", 32'(mon_if.done_rise_o), 1);
        chk("r32.e1cnt", 32'(mon_if.event_cnt_o), 1);
        pulse("r32.e2", 3, 0);
        chk("r32.e2cnt", 32'(mon_if.event_cnt_o), 2);
        pulse("r32.e3", 3, 0);
        chk("r32.e3cnt", 32'(mon_if.event_cnt_o), 0);
        chk("r32.e3irq", 32'(mon_if.irq_o), 1);

        // Two more edges at threshold 2 with no ack: overflow; then ack.
        pulse("r33.e1", 2, 0);
        pulse("r33.e2", 2, 0);
        chk("r33.ovf", 32'(mon_if.overflow_o), 1);
        chk("r33.cnt", 32'(mon_if.event_cnt_o), 0);
        chk("r33.irq", 32'(mon_if.irq_o), 1);
        cyc("r33.ack", 0, 1, 0, 2, 1);
        chk("r33.ackirq", 32'(mon_if.irq_o), 0);
        chk("r33.ackovf", 32'(mon_if.overflow_o), 1);

        // Hit in the same cycle as ack.
        cyc("r34.rst", 1, 1, 0, 1, 0);
        cyc("r34.arm", 0, 1, 0, 1, 0);
        pulse("r34.e1", 1, 0);
        chk("r34.irq1", 32'(mon_if.irq_o), 1);
        pulse("r34.e2", 1, 1);
        chk("r34.irq", 32'(mon_if.irq_o), 1);
        chk("r34.cnt", 32'(mon_if.event_cnt_o), 0);
        chk("r34.ovf", 32'(mon_if.overflow_o), 0);

        // Threshold 0: 17 edges wrap the 4-bit counter, no interrupt.
        cyc("r35.rst", 1, 1, 0, 0, 0);
        irq_seen = 0;
        for (int i = 0; i < 17; i++) begin
            pulse("r35.e", 0, 0);
            if (mon_if.irq_o !== 1'b0) irq_seen = 1;
        end
        chk("r35.cnt", 32'(mon_if.event_cnt_o), 1);
        chk("r35.noirq", 32'(irq_seen), 0);

        // Threshold lowered below the current count.
        cyc("r36.rst", 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) pulse("r36.e", 0, 0);
        chk("r36.cnt5", 32'(mon_if.event_cnt_o), 5);
        pulse("r36.hit", 4, 0);
        chk("r36.irq", 32'(mon_if.irq_o), 1);
        chk("r36.cnt", 32'(mon_if.event_cnt_o), 0);

        // Done held high for 10 cycles gives a single pulse.
        cyc("r37a.lo", 0, 1, 0, 0, 1);
        rises = 0;
        for (int i = 0; i < 10; i++) begin
            cyc("r37a.hold", 0, 1, 1, 0, 0);
            if (mon_if.done_rise_o === 1'b1) rises++;
        end
        chk("r37a.rises", 32'(rises), 1);

        // Disarm while an interrupt is pending.
        cyc("r37b.rst", 1, 1, 0, 2, 0);
        pulse("r37b.e1", 2, 0);
        pulse("r37b.e2", 2, 0);
        pulse("r37b.e3", 2, 0);
        chk("r37b.pend", 32'(mon_if.irq_o), 1);
        cyc("r37b.dis", 0, 0, 0, 2, 0);
        chk("r37b.irq", 32'(mon_if.irq_o), 0);
        chk("r37b.cnt", 32'(mon_if.event_cnt_o), 0);

        // Reset mid-count.
        cyc("r37c.arm", 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) pulse("r37c.e", 0, 0);
        cyc("r37c.rst", 1, 1, 1, 0, 0);
        chk("r37c.cnt", 32'(mon_if.event_cnt_o), 0);
        chk("r37c.irq", 32'(mon_if.irq_o), 0);
        chk("r37c.rise", 32'(mon_if.done_rise_o), 0);
        chk("r37c.ovf", 32'(mon_if.overflow_o), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc("rnd",
                ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 19) != 0),
                1'($urandom),
                int'($urandom_range(0, 6)),
                ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
